// File: rtl/pll_clk_div_gen.sv
// rtl/pll_clk_div_gen.sv - lock-gated multi-channel clock-enable divider with glitch-free divisor updates
module pll_clk_div_gen #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int LOCK_WAIT = 16,
    parameter int DEF_DIV   = 64
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      locked,
    input  logic [NUM_CH*DIV_W-1:0]   div_i,
    input  logic                      div_load,
    input  logic                      sync,
    output logic [NUM_CH-1:0]         outclk,
    output logic [NUM_CH-1:0]         rise_stb,
    output logic [NUM_CH-1:0]         fall_stb,
    output logic                      running,
    output logic                      lock_lost
);

    localparam int WCNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(LOCK_WAIT - 1);
    localparam logic [DIV_W-1:0]  DEF_V     = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0]  ONE_V     = DIV_W'(1);
    localparam logic [DIV_W:0]    TWO_E     = (DIV_W+1)'(2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [WCNT_W-1:0]              wcnt_q, wcnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   act_q, act_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              outclk_q, outclk_d;
    logic [NUM_CH-1:0]              rise_q, rise_d;
    logic [NUM_CH-1:0]              fall_q, fall_d;
    logic                           running_q, running_d;
    logic                           lock_lost_q, lock_lost_d;
    logic                           entering, staying, run_d;

    // A divisor of 1 cannot produce a two-level clock, so it runs as /2.
    function automatic logic [DIV_W:0] eff_div(input logic [DIV_W-1:0] d);
        eff_div = (d == ONE_V) ? TWO_E : {1'b0, d};
    endfunction

    // High phase is the larger half for odd divisors.
    function automatic logic [DIV_W:0] high_time(input logic [DIV_W-1:0] d);
        logic [DIV_W:0] e;
        e = eff_div(d);
        high_time = (e + 1'b1) >> 1;
    endfunction

    // Lock supervision: IDLE -> SETTLE -> RUN once locked has held long enough.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        lock_lost_d = lock_lost_q;
        case (state_q)
            ST_IDLE: begin
                wcnt_d = '0;
                if (locked) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!locked) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked) begin
                    state_d     = ST_IDLE;
                    lock_lost_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    assign entering  = (state_q == ST_SETTLE) && (state_d == ST_RUN);
    assign staying   = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign run_d     = (state_d == ST_RUN);
    assign running_d = run_d;

    // Per-channel counters; divisors only change at a period boundary, RUN entry or sync.
    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        cnt_d    = '0;
        outclk_d = '0;
        rise_d   = '0;
        fall_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (div_load) begin
                shadow_d[c] = div_i[c*DIV_W +: DIV_W];
            end
            if (entering) begin
                act_d[c] = shadow_q[c];
            end else if (staying) begin
                if (sync) begin
                    // sync sees a div_load of the same cycle
                    act_d[c] = shadow_d[c];
                end else if (act_q[c] == '0) begin
                    act_d[c] = shadow_q[c];
                end else if ({1'b0, cnt_q[c]} == (eff_div(act_q[c]) - 1'b1)) begin
                    act_d[c] = shadow_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
            if (run_d && (act_d[c] != '0)) begin
                outclk_d[c] = ({1'b0, cnt_d[c]} < high_time(act_d[c]));
                rise_d[c]   = (cnt_d[c] == '0);
                fall_d[c]   = ({1'b0, cnt_d[c]} == high_time(act_d[c]));
            end
        end
    end

    // State and output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            shadow_q    <= {NUM_CH{DEF_V}};
            act_q       <= {NUM_CH{DEF_V}};
            cnt_q       <= '0;
            outclk_q    <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            running_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            shadow_q    <= shadow_d;
            act_q       <= act_d;
            cnt_q       <= cnt_d;
            outclk_q    <= outclk_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            running_q   <= running_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign outclk    = outclk_q;
    assign rise_stb  = rise_q;
    assign fall_stb  = fall_q;
    assign running   = running_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_clk_div_gen.sv
// tb/tb_pll_clk_div_gen.sv - directed table and sequence checks for pll_clk_div_gen
module tb_pll_clk_div_gen;

    logic        refclk = 1'b0;
    logic        rst;
    logic        locked;
    logic [15:0] div_i;
    logic        div_load;
    logic        sync;
    logic [1:0]  outclk;
    logic [1:0]  rise_stb;
    logic [1:0]  fall_stb;
    logic        running;
    logic        lock_lost;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        lk;
        logic        ld;
        logic        sy;
        logic [15:0] dv;
        logic [1:0]  oc;
        logic [1:0]  rs;
        logic [1:0]  fs;
        logic        run;
        logic        ll;
    } vec_t;

    vec_t tbl [18];

    pll_clk_div_gen #(
        .NUM_CH(2), .DIV_W(8), .LOCK_WAIT(16), .DEF_DIV(64)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .div_i(div_i),
        .div_load(div_load), .sync(sync), .outclk(outclk),
        .rise_stb(rise_stb), .fall_stb(fall_stb),
        .running(running), .lock_lost(lock_lost)
    );

    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {outclk, rise, fall, running, lock_lost}
    function automatic logic [7:0] obs();
        return {outclk, rise_stb, fall_stb, running, lock_lost};
    endfunction

    task automatic def_period(input string tag, input int n);
        logic [1:0] oc, rs, fs;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) tick();
            oc = ((k % 64) < 32) ? 2'b11 : 2'b00;
            rs = ((k % 64) == 0) ? 2'b11 : 2'b00;
            fs = ((k % 64) == 32) ? 2'b11 : 2'b00;
            chk($sformatf("%s_k%0d", tag, k), obs(), {oc, rs, fs, 1'b1, lock_lost});
        end
    endtask

    task automatic go_run(input logic ld, input logic [15:0] dv);
        rst = 1'b1; tick(); rst = 1'b0;
        locked = 1'b1; div_load = ld; div_i = dv;
        tick();
        div_load = 1'b0;
        for (int i = 0; i < 40 && !running; i++) tick();
        chk("go_run_running", {31'd0, running}, 32'd1);
    endtask

    // ch0 starts at /8 and switches to /4 at switch_k; ch1 programmed to 1 runs as /2
    task automatic glitch(input string tag, input int load_k, input int switch_k, input int total);
        int ph, h;
        logic [1:0] oc, rs, fs;
        go_run(1'b1, 16'h0108);
        for (int k = 0; k <= total; k++) begin
            if (k > 0) tick();
            if (k < switch_k) begin ph = k % 8; h = 4; end
            else begin ph = (k - switch_k) % 4; h = 2; end
            oc = {(k % 2) == 0, ph < h};
            rs = {(k % 2) == 0, ph == 0};
            fs = {(k % 2) == 1, ph == h};
            chk($sformatf("%s_k%0d", tag, k), obs(), {oc, rs, fs, 2'b10});
            div_load = (k == load_k);
            div_i    = 16'h0104;
        end
        div_load = 1'b0;
    endtask

    initial begin
        logic [1:0] oc, rs, fs;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0305, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b10, 2'b00, 2'b01, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 16'h0204, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b10, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b10, 2'b10, 2'b01, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

        rst = 1'b1; locked = 1'b0; div_load = 1'b0; sync = 1'b0; div_i = '0;
        tick(); tick();
        chk("reset_state", obs(), 8'h00);
        rst = 1'b0;

        // lock-up with default divisors
        locked = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("lockup_wait%0d", i), {running, outclk, rise_stb}, 5'd0);
        end
        tick();
        def_period("lockup", 64);

        // lock loss for one cycle
        locked = 1'b0;
        tick();
        chk("lock_loss", obs(), 8'h01);
        locked = 1'b1; div_load = 1'b1; div_i = 16'h0005;
        tick();
        div_load = 1'b0;
        chk("relock_settle0", obs(), 8'h01);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("relock_settle%0d", i), obs(), 8'h01);
        end

        // odd divisor, disabled channel, enable on the fly, sync+load, lock drop with sync
        for (int r = 0; r < 18; r++) begin
            locked = tbl[r].lk; div_load = tbl[r].ld; sync = tbl[r].sy; div_i = tbl[r].dv;
            tick();
            chk($sformatf("table_row%0d", r), obs(),
                {tbl[r].oc, tbl[r].rs, tbl[r].fs, tbl[r].run, tbl[r].ll});
        end
        div_load = 1'b0; sync = 1'b0;

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clears_lock_lost", obs(), 8'h00);

        // settle abort: 10 high, 1 low, then a full wait is needed again
        locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("abort_hi%0d", i), obs(), 8'h00);
        end
        locked = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("abort_lo", obs(), 8'h00);
        locked = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("abort_relock%0d", i), obs(), 8'h00);
        end
        tick();
        chk("abort_run", obs(), {2'b11, 2'b11, 2'b00, 2'b10});

        glitch("glitch_mid", 2, 8, 15);
        glitch("glitch_wrap", 7, 16, 23);

        // re-align /6 and /10 with sync at an arbitrary phase
        go_run(1'b1, 16'h0A06);
        for (int i = 0; i < 7; i++) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) tick();
            oc = {(k % 10) < 5, (k % 6) < 3};
            rs = {(k % 10) == 0, (k % 6) == 0};
            fs = {(k % 10) == 5, (k % 6) == 3};
            chk($sformatf("realign_k%0d", k), obs(), {oc, rs, fs, 2'b10});
        end

        // rst mid-RUN restores default divisors
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_run", obs(), 8'h00);
        for (int i = 0; i < 40 && !running; i++) tick();
        chk("rst_relock_running", {31'd0, running}, 32'd1);
        def_period("rst_default", 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
